// File: rtl/fpga_reset_conditioner.sv
// System reset conditioner: button sync/debounce, POR and software sources, hold-time stretch.
// Async assert on rst_ni; rst_no releases synchronously HOLD_CYCLES after all sources clear.
module fpga_reset_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 16,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       button_i,
    input  logic       sw_rst_req_i,
    output logic       rst_no,
    output logic       rst_led_o,
    output logic       btn_pressed_o,
    output logic [1:0] reset_cause_o,
    output logic [7:0] reset_count_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_BTN = 2'b10;
    localparam logic [1:0] CAUSE_SW  = 2'b11;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            rst_q, rst_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;
    logic            sync1_q, sync2_q;
    logic [1:0]      cause_q, cause_d;
    logic [7:0]      count_q, count_d;
    logic            btn_n;

    assign btn_n = BTN_ACTIVE_HIGH ? button_i : ~button_i;

    always_comb begin
        db_cnt_d   = db_cnt_q;
        btn_db_d   = btn_db_q;
        state_d    = state_q;
        rst_d      = rst_q;
        hold_cnt_d = hold_cnt_q;
        cause_d    = cause_q;
        count_d    = count_q;

        // Any return to the settled level restarts the stability window.
        if (sync2_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        case (state_q)
            ST_HOLD: begin
                rst_d = 1'b0;
                if (btn_db_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HC_W'(HOLD_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    rst_d      = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            ST_RUN: begin
                rst_d = 1'b1;
                // Button wins over a coincident software request.
                if (btn_db_q || sw_rst_req_i) begin
                    state_d = ST_HOLD;
                    rst_d   = 1'b0;
                    cause_d = btn_db_q ? CAUSE_BTN : CAUSE_SW;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_HOLD;
                rst_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            btn_db_q   <= 1'b0;
            state_q    <= ST_HOLD;
            rst_q      <= 1'b0;
            hold_cnt_q <= '0;
            cause_q    <= CAUSE_POR;
            count_q    <= 8'd0;
        end else begin
            sync1_q    <= btn_n;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            btn_db_q   <= btn_db_d;
            state_q    <= state_d;
            rst_q      <= rst_d;
            hold_cnt_q <= hold_cnt_d;
            cause_q    <= cause_d;
            count_q    <= count_d;
        end
    end

    assign rst_no        = rst_q;
    assign rst_led_o     = rst_q;
    assign btn_pressed_o = btn_db_q;
    assign reset_cause_o = cause_q;
    assign reset_count_o = count_q;

endmodule

// File: tb/tb_fpga_reset_conditioner.sv
// Directed bench for fpga_reset_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, active-high button.
module tb_fpga_reset_conditioner;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       button_i;
    logic       sw_rst_req_i;
    logic       rst_no;
    logic       rst_led_o;
    logic       btn_pressed_o;
    logic [1:0] reset_cause_o;
    logic [7:0] reset_count_o;

    int checks = 0;
    int errors = 0;

    fpga_reset_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .BTN_ACTIVE_HIGH(1'b1)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .button_i     (button_i),
        .sw_rst_req_i (sw_rst_req_i),
        .rst_no       (rst_no),
        .rst_led_o    (rst_led_o),
        .btn_pressed_o(btn_pressed_o),
        .reset_cause_o(reset_cause_o),
        .reset_count_o(reset_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        button_i     = 1'b0;
        sw_rst_req_i = 1'b0;

        // Power-on reset held for 5 cycles
        tick(5);
        check("por_rst_no",  32'(rst_no),        32'd0);
        check("por_led",     32'(rst_led_o),     32'd0);
        check("por_btn",     32'(btn_pressed_o), 32'd0);
        check("por_cause",   32'(reset_cause_o), 32'd1);
        check("por_count",   32'(reset_count_o), 32'd0);

        // Release: rst_no rises on the 8th edge
        rst_ni = 1'b1;
        tick(7);
        check("por_hold7",   32'(rst_no),        32'd0);
        tick(1);
        check("por_rise8",   32'(rst_no),        32'd1);
        check("por_led_hi",  32'(rst_led_o),     32'd1);
        check("por_cause2",  32'(reset_cause_o), 32'd1);
        check("por_count2",  32'(reset_count_o), 32'd0);

        // Glitch: 3-cycle press must not get through the debouncer
        button_i = 1'b1;
        tick(3);
        button_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("glitch_btn", 32'(btn_pressed_o), 32'd0);
            check("glitch_rst", 32'(rst_no),        32'd1);
        end
        check("glitch_count", 32'(reset_count_o), 32'd0);

        // Button press held for 20 cycles
        button_i = 1'b1;
        tick(5);
        check("btn_e5",       32'(btn_pressed_o), 32'd0);
        tick(1);
        check("btn_e6",       32'(btn_pressed_o), 32'd1);
        check("btn_e6_rst",   32'(rst_no),        32'd1);
        tick(1);
        check("btn_e7_rst",   32'(rst_no),        32'd0);
        check("btn_cause",    32'(reset_cause_o), 32'd2);
        check("btn_count",    32'(reset_count_o), 32'd1);
        tick(13);
        check("btn_held_rst", 32'(rst_no),        32'd0);
        button_i = 1'b0;
        tick(5);
        check("btn_rel_e5",   32'(btn_pressed_o), 32'd1);
        tick(1);
        check("btn_rel_e6",   32'(btn_pressed_o), 32'd0);
        tick(7);
        check("btn_hold7",    32'(rst_no),        32'd0);
        tick(1);
        check("btn_rise8",    32'(rst_no),        32'd1);
        check("btn_count2",   32'(reset_count_o), 32'd1);

        // Software request: rst_no low for exactly 8 cycles
        sw_rst_req_i = 1'b1;
        tick(1);
        sw_rst_req_i = 1'b0;
        check("sw_rst",       32'(rst_no),        32'd0);
        check("sw_cause",     32'(reset_cause_o), 32'd3);
        check("sw_count",     32'(reset_count_o), 32'd2);
        tick(7);
        check("sw_hold7",     32'(rst_no),        32'd0);
        tick(1);
        check("sw_rise8",     32'(rst_no),        32'd1);

        // Simultaneous: software request in the cycle the FSM first sees btn_db
        button_i = 1'b1;
        tick(6);
        check("sim_btn",      32'(btn_pressed_o), 32'd1);
        check("sim_rst_pre",  32'(rst_no),        32'd1);
        sw_rst_req_i = 1'b1;
        tick(1);
        sw_rst_req_i = 1'b0;
        button_i     = 1'b0;
        check("sim_rst",      32'(rst_no),        32'd0);
        check("sim_cause",    32'(reset_cause_o), 32'd2);
        check("sim_count",    32'(reset_count_o), 32'd3);
        tick(5);
        check("sim_btn_hi",   32'(btn_pressed_o), 32'd1);
        tick(1);
        check("sim_btn_lo",   32'(btn_pressed_o), 32'd0);
        tick(7);
        check("sim_hold7",    32'(rst_no),        32'd0);
        tick(1);
        check("sim_rise8",    32'(rst_no),        32'd1);
        check("sim_count2",   32'(reset_count_o), 32'd3);

        // 300 software resets: count saturates at 255
        for (int i = 0; i < 300; i++) begin
            sw_rst_req_i = 1'b1;
            tick(1);
            sw_rst_req_i = 1'b0;
            if (i == 250) check("sat_254", 32'(reset_count_o), 32'd254);
            if (i == 251) check("sat_255", 32'(reset_count_o), 32'd255);
            tick(8);
        end
        check("sat_final",    32'(reset_count_o), 32'd255);
        check("sat_rst",      32'(rst_no),        32'd1);

        // rst_ni pulsed mid-HOLD clears everything at once, hold restarts
        sw_rst_req_i = 1'b1;
        tick(1);
        sw_rst_req_i = 1'b0;
        tick(3);
        check("mid_hold_rst", 32'(rst_no),        32'd0);
        rst_ni = 1'b0;
        #1;
        check("async_rst",    32'(rst_no),        32'd0);
        check("async_count",  32'(reset_count_o), 32'd0);
        check("async_cause",  32'(reset_cause_o), 32'd1);
        tick(2);
        rst_ni = 1'b1;
        tick(7);
        check("async_hold7",  32'(rst_no),        32'd0);
        tick(1);
        check("async_rise8",  32'(rst_no),        32'd1);
        check("async_count2", 32'(reset_count_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
